// File: rtl/dsp_fir_dec_arbiter.sv
// Round-robin front-end for a shared multi-channel FIR decimator: grants one channel sample at a
// time, tracks per-channel decimation phase and tags each returned engine result with its channel.
module dsp_fir_dec_arbiter #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned R       = 2,
  parameter int unsigned W_DIN   = 16,
  parameter int unsigned W_DOUT  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           s_val,
  output logic [N_CH-1:0]           s_rdy,
  input  logic [N_CH*W_DIN-1:0]     s_data,
  output logic [W_DIN-1:0]          eng_din,
  output logic                      eng_din_val,
  output logic [$clog2(N_CH)-1:0]   eng_ch,
  output logic                      eng_start,
  input  logic [W_DOUT-1:0]         eng_dout,
  input  logic                      eng_dout_val,
  output logic [W_DOUT-1:0]         m_dout,
  output logic [$clog2(N_CH)-1:0]   m_ch,
  output logic                      m_val,
  output logic                      err_timeout
);

  localparam int unsigned W_CH = $clog2(N_CH);
  localparam int unsigned W_PH = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned W_T  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [W_PH-1:0] PH_LAST  = W_PH'(R - 1);
  localparam logic [W_T-1:0]  T_LAST   = W_T'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q;
  logic [W_CH-1:0]   rr_q;
  logic [W_PH-1:0]   phase_q [N_CH];
  logic [W_T-1:0]    timer_q;

  logic              found;
  logic [W_CH-1:0]   winner;
  logic [W_CH-1:0]   rr_next;
  logic [W_DIN-1:0]  win_data;

  // First requesting channel at or above rr_q, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      int unsigned idx;
      idx = (int'(rr_q) + i) % N_CH;
      if (!found && s_val[idx]) begin
        found  = 1'b1;
        winner = W_CH'(idx);
      end
    end
    rr_next  = W_CH'((int'(winner) + 1) % N_CH);
    win_data = s_data[int'(winner)*W_DIN +: W_DIN];
  end

  always_comb begin
    s_rdy = '0;
    if (state_q == StIdle && found) begin
      s_rdy[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      timer_q     <= '0;
      for (int k = 0; k < int'(N_CH); k++) begin
        phase_q[k] <= '0;
      end
      eng_din     <= '0;
      eng_din_val <= 1'b0;
      eng_ch      <= '0;
      eng_start   <= 1'b0;
      m_dout      <= '0;
      m_ch        <= '0;
      m_val       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      eng_din_val <= 1'b0;
      m_val       <= 1'b0;
      err_timeout <= 1'b0;
      case (state_q)
        StIdle: begin
          // eng_din/eng_ch double as the captured sample and channel for the whole transaction.
          if (found) begin
            eng_din     <= win_data;
            eng_ch      <= winner;
            eng_start   <= (phase_q[winner] == PH_LAST);
            eng_din_val <= 1'b1;
            rr_q        <= rr_next;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          phase_q[eng_ch] <= eng_start ? '0 : phase_q[eng_ch] + W_PH'(1);
          timer_q         <= '0;
          eng_start       <= 1'b0;
          state_q         <= eng_start ? StWait : StIdle;
        end
        StWait: begin
          // A result arriving on the last timer cycle still wins over the timeout.
          if (eng_dout_val) begin
            m_dout  <= eng_dout;
            m_ch    <= eng_ch;
            m_val   <= 1'b1;
            state_q <= StIdle;
          end else if (timer_q == T_LAST) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end else begin
            timer_q <= timer_q + W_T'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_fir_dec_arbiter.sv
// Directed bench for dsp_fir_dec_arbiter with N_CH=4, R=2, TIMEOUT=64.
module tb_dsp_fir_dec_arbiter;

  localparam int N_CH = 4;
  localparam int R = 2;
  localparam int W_DIN = 16;
  localparam int W_DOUT = 32;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       s_val;
  logic [N_CH-1:0]       s_rdy;
  logic [N_CH*W_DIN-1:0] s_data;
  logic [W_DIN-1:0]      eng_din;
  logic                  eng_din_val;
  logic [1:0]            eng_ch;
  logic                  eng_start;
  logic [W_DOUT-1:0]     eng_dout;
  logic                  eng_dout_val;
  logic [W_DOUT-1:0]     m_dout;
  logic [1:0]            m_ch;
  logic                  m_val;
  logic                  err_timeout;

  int n_vec = 0;
  int n_err = 0;

  dsp_fir_dec_arbiter #(
    .N_CH    (N_CH),
    .R       (R),
    .W_DIN   (W_DIN),
    .W_DOUT  (W_DOUT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_val        (s_val),
    .s_rdy        (s_rdy),
    .s_data       (s_data),
    .eng_din      (eng_din),
    .eng_din_val  (eng_din_val),
    .eng_ch       (eng_ch),
    .eng_start    (eng_start),
    .eng_dout     (eng_dout),
    .eng_dout_val (eng_dout_val),
    .m_dout       (m_dout),
    .m_ch         (m_ch),
    .m_val        (m_val),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_val = '0; s_data = '0; eng_dout = '0; eng_dout_val = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_val = '0; s_data = '0; eng_dout = '0; eng_dout_val = 1'b0;
    #2;
    n_vec++;
    if ({eng_din_val, eng_start, m_val, err_timeout} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0000", {eng_din_val, eng_start, m_val, err_timeout});
    end
    n_vec++;
    if ({eng_din, eng_ch, m_ch, m_dout} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got din=%h ch=%h mch=%h mdout=%h want all 0",
               eng_din, eng_ch, m_ch, m_dout);
    end
    n_vec++;
    if (s_rdy !== 4'b0000) begin
      n_err++; $display("FAIL reset_s_rdy: got %b want 0000", s_rdy);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_ch2();
    s_data[2*W_DIN +: W_DIN] = 16'h0011;
    s_val = 4'b0100;
    #1;
    n_vec++;
    if (s_rdy !== 4'b0100) begin n_err++; $display("FAIL single_rdy: got %b want 0100", s_rdy); end
    tick();
    n_vec++;
    if ({eng_din_val, eng_ch, eng_start, eng_din} !== {1'b1, 2'd2, 1'b0, 16'h0011}) begin
      n_err++;
      $display("FAIL single_issue1: got val=%b ch=%0d start=%b din=%h want 1 2 0 0011",
               eng_din_val, eng_ch, eng_start, eng_din);
    end
    s_data[2*W_DIN +: W_DIN] = 16'h0022;
    tick();
    n_vec++;
    if ({eng_din_val, s_rdy} !== {1'b0, 4'b0100}) begin
      n_err++; $display("FAIL single_idle_t2: got val=%b rdy=%b want 0 0100", eng_din_val, s_rdy);
    end
    tick();
    n_vec++;
    if ({eng_din_val, eng_ch, eng_start, eng_din} !== {1'b1, 2'd2, 1'b1, 16'h0022}) begin
      n_err++;
      $display("FAIL single_issue2: got val=%b ch=%0d start=%b din=%h want 1 2 1 0022",
               eng_din_val, eng_ch, eng_start, eng_din);
    end
    s_val = '0;
    repeat (33) tick();
    n_vec++;
    if (m_val !== 1'b0) begin n_err++; $display("FAIL single_early_mval: got %b want 0", m_val); end
    eng_dout = 32'h12345678; eng_dout_val = 1'b1;
    tick();
    eng_dout_val = 1'b0;
    n_vec++;
    if ({m_val, m_ch, m_dout} !== {1'b1, 2'd2, 32'h12345678}) begin
      n_err++;
      $display("FAIL single_result: got val=%b ch=%0d dout=%h want 1 2 12345678", m_val, m_ch, m_dout);
    end
    tick();
    n_vec++;
    if (m_val !== 1'b0) begin n_err++; $display("FAIL single_mval_pulse: got %b want 0", m_val); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N_CH; k++) s_data[k*W_DIN +: W_DIN] = 16'h00A0 + 16'(k);
    s_val = 4'hF;
    #1;
    for (int g = 0; g < 8; g++) begin
      int ch;
      logic st;
      ch = g % N_CH;
      st = (g >= N_CH);
      n_vec++;
      if (s_rdy !== 4'(1 << ch)) begin
        n_err++; $display("FAIL rr_rdy[%0d]: got %b want %b", g, s_rdy, 4'(1 << ch));
      end
      tick();
      n_vec++;
      if ({eng_din_val, eng_ch, eng_start, eng_din} !== {1'b1, 2'(ch), st, 16'h00A0 + 16'(ch)}) begin
        n_err++;
        $display("FAIL rr_issue[%0d]: got val=%b ch=%0d start=%b din=%h want 1 %0d %b %h", g,
                 eng_din_val, eng_ch, eng_start, eng_din, ch, st, 16'h00A0 + 16'(ch));
      end
      tick();
      if (st) begin
        n_vec++;
        if (s_rdy !== 4'b0000) begin n_err++; $display("FAIL rr_wait_rdy0[%0d]: got %b want 0000", g, s_rdy); end
        tick();
        n_vec++;
        if (s_rdy !== 4'b0000) begin n_err++; $display("FAIL rr_wait_rdy1[%0d]: got %b want 0000", g, s_rdy); end
        eng_dout = 32'hA000_0000 + 32'(g); eng_dout_val = 1'b1;
        tick();
        eng_dout_val = 1'b0;
        n_vec++;
        if ({m_val, m_ch, m_dout} !== {1'b1, 2'(ch), 32'hA000_0000 + 32'(g)}) begin
          n_err++;
          $display("FAIL rr_result[%0d]: got val=%b ch=%0d dout=%h want 1 %0d %h", g, m_val, m_ch,
                   m_dout, ch, 32'hA000_0000 + 32'(g));
        end
      end
    end
    s_val = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    s_data[1*W_DIN +: W_DIN] = 16'h1111;
    s_val = 4'b0010;
    tick(); tick(); tick();
    n_vec++;
    if ({eng_din_val, eng_ch, eng_start} !== {1'b1, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL to_issue: got val=%b ch=%0d start=%b want 1 1 1", eng_din_val, eng_ch, eng_start);
    end
    s_val = 4'b0001;
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      n_vec++;
      if ({err_timeout, m_val, s_rdy} !== 6'b0) begin
        n_err++;
        $display("FAIL to_wait[%0d]: got err=%b mval=%b rdy=%b want 0 0 0000", i, err_timeout, m_val, s_rdy);
      end
      tick();
    end
    n_vec++;
    if ({err_timeout, m_val, s_rdy} !== {1'b1, 1'b0, 4'b0001}) begin
      n_err++;
      $display("FAIL to_fire: got err=%b mval=%b rdy=%b want 1 0 0001", err_timeout, m_val, s_rdy);
    end
    tick();
    n_vec++;
    if ({err_timeout, eng_din_val, eng_ch} !== {1'b0, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL to_next: got err=%b val=%b ch=%0d want 0 1 0", err_timeout, eng_din_val, eng_ch);
    end
    s_val = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    s_val = 4'b1000;
    tick(); tick(); tick();
    s_val = '0;
    tick();
    repeat (TIMEOUT - 1) tick();
    eng_dout = 32'hCAFEF00D; eng_dout_val = 1'b1;
    tick();
    eng_dout_val = 1'b0;
    n_vec++;
    if ({m_val, err_timeout, m_ch, m_dout} !== {1'b1, 1'b0, 2'd3, 32'hCAFEF00D}) begin
      n_err++;
      $display("FAIL sim_result: got val=%b err=%b ch=%0d dout=%h want 1 0 3 cafef00d",
               m_val, err_timeout, m_ch, m_dout);
    end
    tick();
    n_vec++;
    if ({m_val, err_timeout} !== 2'b00) begin
      n_err++; $display("FAIL sim_after: got val=%b err=%b want 0 0", m_val, err_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    s_val = 4'b0001;
    tick();
    s_val = 4'b0010;
    tick(); tick(); tick(); tick();
    n_vec++;
    if ({eng_ch, eng_start} !== {2'd1, 1'b1}) begin
      n_err++; $display("FAIL rmw_issue: got ch=%0d start=%b want 1 1", eng_ch, eng_start);
    end
    s_val = '0;
    repeat (6) tick();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({eng_ch, eng_din, eng_din_val, m_val} !== '0) begin
      n_err++;
      $display("FAIL rmw_async: got ch=%0d din=%h val=%b mval=%b want 0 0 0 0",
               eng_ch, eng_din, eng_din_val, m_val);
    end
    tick();
    rst_n = 1'b1;
    tick();
    eng_dout = 32'hDEAD_BEEF; eng_dout_val = 1'b1;
    tick();
    eng_dout_val = 1'b0;
    n_vec++;
    if ({m_val, m_dout} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL rmw_late_result: got val=%b dout=%h want 0 0", m_val, m_dout);
    end
    s_val = 4'b0001;
    #1;
    n_vec++;
    if (s_rdy !== 4'b0001) begin n_err++; $display("FAIL rmw_rdy: got %b want 0001", s_rdy); end
    tick();
    n_vec++;
    if ({eng_din_val, eng_ch, eng_start} !== {1'b1, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rmw_phase: got val=%b ch=%0d start=%b want 1 0 0", eng_din_val, eng_ch, eng_start);
    end
    s_val = '0;
    tick();
  endtask

  task automatic test_stray();
    do_reset();
    eng_dout = 32'h5555_AAAA; eng_dout_val = 1'b1;
    tick();
    eng_dout_val = 1'b0;
    n_vec++;
    if (m_val !== 1'b0) begin n_err++; $display("FAIL stray_idle: got mval=%b want 0", m_val); end
    s_val = 4'b0100;
    tick();
    n_vec++;
    if ({eng_din_val, eng_ch, eng_start} !== {1'b1, 2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL stray_issue1: got val=%b ch=%0d start=%b want 1 2 0", eng_din_val, eng_ch, eng_start);
    end
    s_val = '0; eng_dout_val = 1'b1;
    tick();
    eng_dout_val = 1'b0;
    n_vec++;
    if ({m_val, eng_din_val} !== 2'b00) begin
      n_err++; $display("FAIL stray_issue_mval: got mval=%b val=%b want 0 0", m_val, eng_din_val);
    end
    s_val = 4'b0100;
    #1;
    n_vec++;
    if (s_rdy !== 4'b0100) begin n_err++; $display("FAIL stray_state: got rdy=%b want 0100", s_rdy); end
    tick();
    n_vec++;
    if ({eng_ch, eng_start} !== {2'd2, 1'b1}) begin
      n_err++; $display("FAIL stray_phase: got ch=%0d start=%b want 2 1", eng_ch, eng_start);
    end
    s_val = '0;
    tick();
    eng_dout = 32'h0BAD_F00D; eng_dout_val = 1'b1;
    tick();
    eng_dout_val = 1'b0;
    n_vec++;
    if ({m_val, m_ch, m_dout} !== {1'b1, 2'd2, 32'h0BAD_F00D}) begin
      n_err++;
      $display("FAIL stray_result: got val=%b ch=%0d dout=%h want 1 2 0badf00d", m_val, m_ch, m_dout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_ch2();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_stray();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
